// File: rtl/ltm_frame_reader.sv
// LTM panel timing generator and SDRAM read-FIFO pixel unpacker.
// Read requests lead DEN by RD_LAT+1 clocks so each returned word pair lands on its pixel.
module ltm_frame_reader #(
    parameter int H_ACTIVE = 800,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 215,
    parameter int H_FP     = 40,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 22,
    parameter int V_FP     = 22,
    parameter int RD_LAT   = 1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iDisp_En,
    input  logic        iClr_Err,
    input  logic [15:0] iRd1_data,
    input  logic [15:0] iRd2_data,
    input  logic        iRd_empty,
    output logic        oRd_req,
    output logic        oRd_load,
    output logic [7:0]  oLCD_R,
    output logic [7:0]  oLCD_G,
    output logic [7:0]  oLCD_B,
    output logic        oHD,
    output logic        oVD,
    output logic        oDEN,
    output logic        oUnderflow
);

    localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;
    localparam int REQ_START   = H_ACT_START - RD_LAT - 1;
    localparam int REQ_END     = H_ACT_END - RD_LAT - 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ZERO   = {HW{1'b0}};
    localparam logic [VW-1:0] V_ZERO   = {VW{1'b0}};
    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [VW-1:0] V_ONE    = VW'(1);

    // Word pair layout: w1 = 0 G[7:3] B[7:0] xx, w2 = 0 G[2:0] xx R[7:0] xx
    function automatic logic [23:0] unpackPixel(input logic [15:0] w1, input logic [15:0] w2);
        return {w2[9:2], w1[14:10], w2[14:12], w1[9:2]};
    endfunction

    logic [HW-1:0]     hCnt_r;
    logic [VW-1:0]     vCnt_r;
    logic              started_r;
    logic              en_r;
    logic [RD_LAT-1:0] goodPipe_r;
    logic              hd_r;
    logic              vd_r;
    logic              den_r;
    logic              rdReq_r;
    logic              rdLoad_r;
    logic              underflow_r;
    logic [7:0]        lcdR_r;
    logic [7:0]        lcdG_r;
    logic [7:0]        lcdB_r;

    logic              frameStart_s;
    logic              hLast_s;
    logic              vLast_s;
    logic              hActive_s;
    logic              vActive_s;
    logic              reqWin_s;
    logic              rdGood_s;
    logic [RD_LAT:0]   goodChain_s;
    logic              pixValid_s;
    logic [23:0]       pix_s;
    logic              unusedBits_s;

    // Decode the raster position and the request/data alignment chain
    always_comb begin
        frameStart_s = (hCnt_r == H_ZERO) && (vCnt_r == V_ZERO);
        hLast_s      = (hCnt_r == H_LAST);
        vLast_s      = (vCnt_r == V_LAST);
        hActive_s    = (hCnt_r >= HW'(H_ACT_START)) && (hCnt_r < HW'(H_ACT_END));
        vActive_s    = (vCnt_r >= VW'(V_ACT_START)) && (vCnt_r < VW'(V_ACT_END));
        reqWin_s     = (hCnt_r >= HW'(REQ_START)) && (hCnt_r < HW'(REQ_END));
        rdGood_s     = rdReq_r && !iRd_empty;
        goodChain_s  = {goodPipe_r, rdGood_s};
        pixValid_s   = goodChain_s[RD_LAT] && hActive_s && vActive_s;
        pix_s        = unpackPixel(iRd1_data, iRd2_data);
    end

    assign unusedBits_s = ^{iRd1_data[15], iRd1_data[1:0], iRd2_data[15], iRd2_data[11:10], iRd2_data[1:0]};

    // Raster counters
    always_ff @(posedge iClk) begin
        if (iRst) begin
            hCnt_r <= H_ZERO;
            vCnt_r <= V_ZERO;
        end else if (hLast_s) begin
            hCnt_r <= H_ZERO;
            vCnt_r <= vLast_s ? V_ZERO : (vCnt_r + V_ONE);
        end else begin
            hCnt_r <= hCnt_r + H_ONE;
        end
    end

    // Frame enable: the first frame start after reset is skipped so that frame is always blank
    always_ff @(posedge iClk) begin
        if (iRst) begin
            started_r <= 1'b0;
            en_r      <= 1'b0;
        end else if (frameStart_s) begin
            started_r <= 1'b1;
            en_r      <= started_r && iDisp_En;
        end
    end

    // Track which outstanding requests will return usable data
    always_ff @(posedge iClk) begin
        if (iRst) begin
            goodPipe_r <= {RD_LAT{1'b0}};
        end else begin
            goodPipe_r <= goodChain_s[RD_LAT-1:0];
        end
    end

    // Registered panel timing, request and pixel outputs
    always_ff @(posedge iClk) begin
        if (iRst) begin
            hd_r     <= 1'b1;
            vd_r     <= 1'b1;
            den_r    <= 1'b0;
            rdReq_r  <= 1'b0;
            rdLoad_r <= 1'b0;
            lcdR_r   <= 8'h00;
            lcdG_r   <= 8'h00;
            lcdB_r   <= 8'h00;
        end else begin
            hd_r     <= (hCnt_r >= HW'(H_SYNC));
            vd_r     <= (vCnt_r >= VW'(V_SYNC));
            den_r    <= hActive_s && vActive_s;
            rdReq_r  <= en_r && reqWin_s && vActive_s;
            rdLoad_r <= frameStart_s;
            {lcdR_r, lcdG_r, lcdB_r} <= pixValid_s ? pix_s : 24'h000000;
        end
    end

    // Sticky underflow flag; a new underflow outranks a same-cycle clear
    always_ff @(posedge iClk) begin
        if (iRst) begin
            underflow_r <= 1'b0;
        end else if (rdReq_r && iRd_empty) begin
            underflow_r <= 1'b1;
        end else if (iClr_Err) begin
            underflow_r <= 1'b0;
        end
    end

    assign oRd_req    = rdReq_r;
    assign oRd_load   = rdLoad_r;
    assign oLCD_R     = lcdR_r;
    assign oLCD_G     = lcdG_r;
    assign oLCD_B     = lcdB_r;
    assign oHD        = hd_r;
    assign oVD        = vd_r;
    assign oDEN       = den_r;
    assign oUnderflow = underflow_r;

endmodule

// File: tb/tb_ltm_frame_reader.sv
// Directed bench for ltm_frame_reader using a shrunken raster (16 x 8 clocks per frame)
// and two instances with read latency 1 and 3.
module tb_ltm_frame_reader;

    localparam int HS = 1, HB = 5, HA = 8, HF = 2;
    localparam int VS = 1, VB = 2, VA = 3, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME = HT * VT;

    typedef struct {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } vec_t;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iDisp_En = 1'b1;
    logic        iClr_Err = 1'b0;
    logic        emptyA = 1'b0;
    logic        emptyB = 1'b0;
    logic [15:0] rd1A, rd2A, rd1B, rd2B;
    logic        reqA, loadA, hdA, vdA, denA, ufA;
    logic        reqB, loadB, hdB, vdB, denB, ufB;
    logic [7:0]  rA, gA, bA, rB, gB, bB;

    int          nTests = 0;
    int          nFail = 0;
    bit          constMode = 1'b0;
    logic [15:0] constRd1 = 16'h0000;
    logic [15:0] constRd2 = 16'h0000;
    logic [23:0] constPix = 24'h000000;
    int          cntA = 0, cntB = 0;
    int          pipeA[8], pipeB[8];
    int          pixA = 0, pixB = 0;
    vec_t        vecs[7];

    ltm_frame_reader #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_FP(VF), .RD_LAT(1)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iDisp_En(iDisp_En), .iClr_Err(iClr_Err),
        .iRd1_data(rd1A), .iRd2_data(rd2A), .iRd_empty(emptyA),
        .oRd_req(reqA), .oRd_load(loadA), .oLCD_R(rA), .oLCD_G(gA), .oLCD_B(bA),
        .oHD(hdA), .oVD(vdA), .oDEN(denA), .oUnderflow(ufA)
    );

    ltm_frame_reader #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_FP(VF), .RD_LAT(3)
    ) dut3 (
        .iClk(iClk), .iRst(iRst), .iDisp_En(iDisp_En), .iClr_Err(iClr_Err),
        .iRd1_data(rd1B), .iRd2_data(rd2B), .iRd_empty(emptyB),
        .oRd_req(reqB), .oRd_load(loadB), .oLCD_R(rB), .oLCD_G(gB), .oLCD_B(bB),
        .oHD(hdB), .oVD(vdB), .oDEN(denB), .oUnderflow(ufB)
    );

    always #5 iClk = ~iClk;

    // FIFO model, latency 1: returns the request index (B=idx, R=~idx) or a constant pair
    always @(posedge iClk) begin
        for (int k = 7; k > 0; k--) pipeA[k] = pipeA[k-1];
        pipeA[0] = cntA;
        if (reqA === 1'b1) cntA++;
        #1;
        if (constMode) begin
            rd1A = constRd1;
            rd2A = constRd2;
        end else begin
            rd1A = {6'd0, 8'(pipeA[0]), 2'd0};
            rd2A = {6'd0, ~8'(pipeA[0]), 2'd0};
        end
    end

    // FIFO model, latency 3
    always @(posedge iClk) begin
        for (int k = 7; k > 0; k--) pipeB[k] = pipeB[k-1];
        pipeB[0] = cntB;
        if (reqB === 1'b1) cntB++;
        #1;
        if (constMode) begin
            rd1B = constRd1;
            rd2B = constRd2;
        end else begin
            rd1B = {6'd0, 8'(pipeB[2]), 2'd0};
            rd2B = {6'd0, ~8'(pipeB[2]), 2'd0};
        end
    end

    task automatic tick();
        @(posedge iClk);
        #2;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic sigOf(input int sel);
        case (sel)
            0:       return loadA;
            1:       return denA;
            2:       return reqA;
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitSig(input int sel, input logic val, input string nm);
        int n;
        n = 0;
        while (sigOf(sel) !== val && n < 3 * FRAME) begin
            tick();
            n++;
        end
        check({"wait ", nm}, 32'(sigOf(sel)), 32'(val));
    endtask

    task automatic setVec(input int k);
        constRd1 = vecs[k].rd1;
        constRd2 = vecs[k].rd2;
        constPix = {vecs[k].r, vecs[k].g, vecs[k].b};
    endtask

    // Checks one whole frame starting at the cycle where oRd_load is high
    task automatic runFrame(input bit expEn, input string tag);
        int hc, vc, tErrA, tErrB, pErrA, pErrB, denCnt, reqCnt, fReqA, fReqB, fDenA, fDenB;
        bit vAct, act, rqA, rqB;
        logic [5:0] expA, expB;
        logic [23:0] pxA, pxB;
        tErrA = 0; tErrB = 0; pErrA = 0; pErrB = 0; denCnt = 0; reqCnt = 0;
        fReqA = -1; fReqB = -1; fDenA = -1; fDenB = -1;
        for (int i = 0; i < FRAME; i++) begin
            hc   = i % HT;
            vc   = i / HT;
            vAct = (vc >= VS + VB) && (vc < VS + VB + VA);
            act  = vAct && (hc >= HS + HB) && (hc < HS + HB + HA);
            rqA  = expEn && vAct && (hc >= HS + HB - 2) && (hc < HS + HB + HA - 2);
            rqB  = expEn && vAct && (hc >= HS + HB - 4) && (hc < HS + HB + HA - 4);
            expA = {hc >= HS, vc >= VS, act, rqA, i == 0, 1'b0};
            expB = {hc >= HS, vc >= VS, act, rqB, i == 0, 1'b0};
            if ({hdA, vdA, denA, reqA, loadA, ufA} !== expA) tErrA++;
            if ({hdB, vdB, denB, reqB, loadB, ufB} !== expB) tErrB++;
            pxA = 24'h0;
            pxB = 24'h0;
            if (act && expEn) begin
                pxA = constMode ? constPix : {~8'(pixA), 8'h00, 8'(pixA)};
                pxB = constMode ? constPix : {~8'(pixB), 8'h00, 8'(pixB)};
                pixA++;
                pixB++;
            end
            if ({rA, gA, bA} !== pxA) pErrA++;
            if ({rB, gB, bB} !== pxB) pErrB++;
            if (denA === 1'b1) denCnt++;
            if (reqA === 1'b1) reqCnt++;
            if (reqA === 1'b1 && fReqA < 0) fReqA = i;
            if (reqB === 1'b1 && fReqB < 0) fReqB = i;
            if (denA === 1'b1 && fDenA < 0) fDenA = i;
            if (denB === 1'b1 && fDenB < 0) fDenB = i;
            tick();
        end
        check({tag, " timing L1"}, tErrA, 0);
        check({tag, " timing L3"}, tErrB, 0);
        check({tag, " pixels L1"}, pErrA, 0);
        check({tag, " pixels L3"}, pErrB, 0);
        check({tag, " DEN clocks"}, denCnt, VA * HA);
        check({tag, " req clocks"}, reqCnt, expEn ? VA * HA : 0);
        if (expEn) begin
            check({tag, " req->DEN L1"}, fDenA - fReqA, 2);
            check({tag, " req->DEN L3"}, fDenB - fReqB, 4);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, " L1"}, {2'b00, hdA, vdA, denA, reqA, loadA, ufA, rA, gA, bA}, {2'b00, 6'b110000, 24'h000000});
        check({tag, " L3"}, {2'b00, hdB, vdB, denB, reqB, loadB, ufB, rB, gB, bB}, {2'b00, 6'b110000, 24'h000000});
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h5155, 16'h2EAA, 8'hAA, 8'hA2, 8'h55};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[2] = '{16'h8000, 16'h8000, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{16'h7C00, 16'h0000, 8'h00, 8'hF8, 8'h00};
        vecs[4] = '{16'h0000, 16'h7000, 8'h00, 8'h07, 8'h00};
        vecs[5] = '{16'h0003, 16'h03FC, 8'hFF, 8'h00, 8'h00};
        vecs[6] = '{16'h03FC, 16'h0C00, 8'h00, 8'h00, 8'hFF};

        repeat (3) tick();
        checkReset("reset state");

        // Release: rd_load pulses at once, first frame blank, second frame carries word 0 onward
        iRst = 1'b0;
        tick();
        check("rd_load after release", 32'(loadA), 32'd1);
        runFrame(1'b0, "first frame");
        runFrame(1'b1, "count frame");

        // Unpack table, one active line per vector
        constMode = 1'b1;
        for (int k = 0; k < 7; k++) begin
            setVec(k);
            waitSig(1, 1'b1, "unpack DEN");
            n = 0;
            while (denA === 1'b1 && n < HA + 2) begin
                check($sformatf("unpack v%0d L1", k), {8'h00, rA, gA, bA}, {8'h00, constPix});
                check($sformatf("unpack v%0d L3", k), {8'h00, rB, gB, bB}, {8'h00, constPix});
                tick();
                n++;
            end
            check($sformatf("unpack v%0d line length", k), n, HA);
        end

        // Underflow on the first request of a line
        setVec(0);
        waitSig(0, 1'b1, "frame start");
        waitSig(2, 1'b1, "first req");
        emptyA = 1'b1;
        tick();
        emptyA = 1'b0;
        check("underflow set", 32'(ufA), 32'd1);
        tick();
        check("underflow pixel", {7'd0, denA, rA, gA, bA}, {7'd0, 1'b1, 24'h000000});
        tick();
        check("pixel after underflow", {7'd0, denA, rA, gA, bA}, {7'd0, 1'b1, 24'hAAA255});
        repeat (20) tick();
        check("underflow sticky", 32'(ufA), 32'd1);
        iClr_Err = 1'b1;
        tick();
        iClr_Err = 1'b0;
        check("underflow cleared", 32'(ufA), 32'd0);
        waitSig(2, 1'b1, "req again");
        emptyA = 1'b1;
        iClr_Err = 1'b1;
        tick();
        emptyA = 1'b0;
        iClr_Err = 1'b0;
        check("set beats clear", 32'(ufA), 32'd1);
        iClr_Err = 1'b1;
        tick();
        iClr_Err = 1'b0;
        check("clear after set", 32'(ufA), 32'd0);

        // Enable dropped mid-frame: current frame completes, next one is blank
        waitSig(0, 1'b1, "frame start");
        iDisp_En = 1'b0;
        runFrame(1'b1, "enable-drop frame");
        iDisp_En = 1'b1;
        runFrame(1'b0, "disabled frame");
        runFrame(1'b1, "re-enabled frame");

        // Reset in the middle of an active line, with an underflow pending
        waitSig(0, 1'b1, "frame start");
        waitSig(1, 1'b1, "DEN before reset");
        emptyA = 1'b1;
        tick();
        emptyA = 1'b0;
        check("underflow before reset", 32'(ufA), 32'd1);
        tick();
        iRst = 1'b1;
        tick();
        checkReset("mid-line reset");
        tick();
        iRst = 1'b0;
        tick();
        check("rd_load after re-release", 32'(loadA), 32'd1);
        runFrame(1'b0, "post-reset frame");
        runFrame(1'b1, "post-reset enabled frame");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
